// File: rtl/byte_pair_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_pkg
// Brief    : Shared defaults, FSM state type and sizing helper for the packer.
// Revision : 1.0 - initial release
// ============================================================================
package byte_pair_pkg;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_PAD   = 8'h00;

    typedef enum logic [0:0] {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pack_state_e;

    // One extra bit so a full FIFO (count == DEPTH) is distinguishable from empty.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pair_fifo
// Brief    : Synchronous DEPTH-entry FIFO of byte pairs, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module pair_fifo
    import byte_pair_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  logic [DW-1:0]                   i_wdata,
    input  logic                            i_pop,
    output logic [DW-1:0]                   o_rdata,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [count_width(DEPTH)-1:0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_packer
// Brief    : Packs a byte stream into (first, second) pairs behind a pair FIFO.
//            Define PACKER_FLUSH_EN to add the flush port (emits {hold, PAD}).
// Revision : 1.0 - initial release
// ============================================================================
module byte_pair_packer
    import byte_pair_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] PAD   = WIDTH'(DEF_PAD)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
`ifdef PACKER_FLUSH_EN
    input  logic                            flush,
`endif
    output logic [WIDTH-1:0]                out_d1,
    output logic [WIDTH-1:0]                out_d2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            odd_pending
);

    pack_state_e        state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               w_flush_req;
    logic               w_pop;
    logic               w_can_push;
    logic               w_accept;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [2*WIDTH-1:0] w_push_data;
    logic [2*WIDTH-1:0] w_head;

`ifdef PACKER_FLUSH_EN
    assign w_flush_req = flush;
`else
    assign w_flush_req = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a full FIFO can still take a pair.
    assign w_pop      = !w_empty && out_ready;
    assign w_can_push = !w_full || w_pop;
    assign in_ready   = (state_q == EVEN) || w_can_push;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EVEN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EVEN: if (w_accept) state_d = ODD;
            ODD:  if (w_accept || (w_flush_req && w_can_push)) state_d = EVEN;
            default: state_d = EVEN;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        w_push      = 1'b0;
        w_push_data = {hold_q, in_data};
        case (state_q)
            EVEN: begin
                if (w_accept) hold_d = in_data;
            end
            ODD: begin
                w_push = w_accept || (w_flush_req && w_can_push);
                if (!w_accept) w_push_data = {hold_q, PAD};
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    pair_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign {out_d1, out_d2} = w_head;
    assign out_valid        = !w_empty;
    assign odd_pending      = (state_q == ODD);

endmodule
`default_nettype wire
